// File: rtl/tts_pkg.sv
// rtl/tts_pkg.sv - shared config opcodes, header field positions and table entry type
package tts_pkg;

    localparam logic [7:0] CFG_OP_WRITE_ENTRY = 8'h01;
    localparam logic [7:0] CFG_OP_SET_ENABLE  = 8'h02;

    localparam int HDR_OP_LSB  = 56;
    localparam int HDR_IDX_LSB = 48;
    localparam int HDR_EN_BIT  = 0;

    localparam int ENTRY_SYM_W   = 64;
    localparam int ENTRY_PRICE_W = 32;
    localparam int ENTRY_VOL_W   = 32;

    typedef struct packed {
        logic [ENTRY_SYM_W-1:0]   symbol;
        logic [ENTRY_PRICE_W-1:0] price;
        logic [ENTRY_VOL_W-1:0]   volume;
    } strat_entry_t;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_SYM,
        ST_PV,
        ST_WR,
        ST_DRAIN_SYM,
        ST_DRAIN_PV
    } cfg_state_t;

endpackage

// File: rtl/hpb_cfg_rx_if.sv
// rtl/hpb_cfg_rx_if.sv - config word stream in, strategy table write port out
interface hpb_cfg_rx_if #(
    parameter int CFG_DATA_W = 64,
    parameter int ADDR_W     = 8,
    parameter int SYM_W      = 64,
    parameter int PRICE_W    = 32,
    parameter int VOL_W      = 32
);
    logic                  in_config_valid;
    logic [CFG_DATA_W-1:0] in_config_data;
    logic                  in_config_accept;
    logic                  tbl_wr_en;
    logic [ADDR_W-1:0]     tbl_wr_addr;
    logic [SYM_W-1:0]      tbl_wr_symbol;
    logic [PRICE_W-1:0]    tbl_wr_price;
    logic [VOL_W-1:0]      tbl_wr_volume;
    logic                  tbl_wr_ready;

    modport master (
        output in_config_valid, in_config_data, tbl_wr_ready,
        input  in_config_accept, tbl_wr_en, tbl_wr_addr, tbl_wr_symbol,
               tbl_wr_price, tbl_wr_volume
    );

    modport slave (
        input  in_config_valid, in_config_data, tbl_wr_ready,
        output in_config_accept, tbl_wr_en, tbl_wr_addr, tbl_wr_symbol,
               tbl_wr_price, tbl_wr_volume
    );
endinterface

// File: rtl/cfg_sat_counter.sv
// rtl/cfg_sat_counter.sv - status counter that sticks at all-ones
module cfg_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: rtl/hpb_cfg_rx.sv
// rtl/hpb_cfg_rx.sv - parses host config records into strategy table writes
module hpb_cfg_rx
    import tts_pkg::*;
#(
    parameter int CFG_DATA_W = 64,
    parameter int TBL_DEPTH  = 256,
    parameter int ADDR_W     = 8,
    parameter int SYM_W      = 64,
    parameter int PRICE_W    = 32,
    parameter int VOL_W      = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    hpb_cfg_rx_if.slave      cfg,
    output logic             strat_enable,
    output logic [CNT_W-1:0] cfg_rec_cnt,
    output logic [CNT_W-1:0] cfg_err_cnt
);
    cfg_state_t        state;
    strat_entry_t      entry;
    logic [ADDR_W-1:0] addr_q;
    logic              accept_q;
    logic              wr_en_q;

    logic [7:0] hdr_op;
    logic [7:0] hdr_idx;
    logic       cfg_hs, wr_hs, set_en_hs, illegal_hs, drain_done, idx_ok;

    assign hdr_op  = cfg.in_config_data[HDR_OP_LSB +: 8];
    assign hdr_idx = cfg.in_config_data[HDR_IDX_LSB +: 8];
    // Full 8-bit index is compared so out-of-range headers are caught even for small tables.
    assign idx_ok  = int'(hdr_idx) < TBL_DEPTH;

    assign cfg_hs     = cfg.in_config_valid && accept_q;
    assign wr_hs      = wr_en_q && cfg.tbl_wr_ready;
    assign set_en_hs  = cfg_hs && (state == ST_HDR) && (hdr_op == CFG_OP_SET_ENABLE);
    assign illegal_hs = cfg_hs && (state == ST_HDR) &&
                        (hdr_op != CFG_OP_SET_ENABLE) && (hdr_op != CFG_OP_WRITE_ENTRY);
    assign drain_done = cfg_hs && (state == ST_DRAIN_PV);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_HDR;
            accept_q     <= 1'b1;
            wr_en_q      <= 1'b0;
            entry        <= '0;
            addr_q       <= '0;
            strat_enable <= 1'b0;
        end else begin
            case (state)
                ST_HDR: if (cfg_hs) begin
                    if (hdr_op == CFG_OP_WRITE_ENTRY) begin
                        if (idx_ok) begin
                            addr_q <= hdr_idx[ADDR_W-1:0];
                            state  <= ST_SYM;
                        end else begin
                            state  <= ST_DRAIN_SYM;
                        end
                    end else if (hdr_op == CFG_OP_SET_ENABLE) begin
                        strat_enable <= cfg.in_config_data[HDR_EN_BIT];
                    end
                end
                ST_SYM: if (cfg_hs) begin
                    entry.symbol <= cfg.in_config_data[63:0];
                    state        <= ST_PV;
                end
                ST_PV: if (cfg_hs) begin
                    entry.price  <= cfg.in_config_data[63:32];
                    entry.volume <= cfg.in_config_data[31:0];
                    wr_en_q      <= 1'b1;
                    accept_q     <= 1'b0;
                    state        <= ST_WR;
                end
                ST_WR: if (wr_hs) begin
                    wr_en_q  <= 1'b0;
                    accept_q <= 1'b1;
                    state    <= ST_HDR;
                end
                ST_DRAIN_SYM: if (cfg_hs) state <= ST_DRAIN_PV;
                ST_DRAIN_PV:  if (cfg_hs) state <= ST_HDR;
                default: begin
                    state    <= ST_HDR;
                    accept_q <= 1'b1;
                    wr_en_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg.in_config_accept = accept_q;
    assign cfg.tbl_wr_en        = wr_en_q;
    assign cfg.tbl_wr_addr      = addr_q;
    assign cfg.tbl_wr_symbol    = entry.symbol;
    assign cfg.tbl_wr_price     = entry.price;
    assign cfg.tbl_wr_volume    = entry.volume;

    cfg_sat_counter #(.CNT_W(CNT_W)) u_rec_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (set_en_hs || wr_hs),
        .count   (cfg_rec_cnt)
    );

    cfg_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (illegal_hs || drain_done),
        .count   (cfg_err_cnt)
    );

    // One record in flight at a time, so these two completions are mutually exclusive.
    a_no_dual_rec: assert property (@(posedge clk) disable iff (!reset_n) !(set_en_hs && wr_hs));

endmodule
